// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared playfield geometry, datapath widths and the
//                collision-checker state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package tetris_pkg;

   // Default playfield size (columns x rows), row 0 at the top.
   localparam int c_board_w = 10;
   localparam int c_board_h = 20;

   // Signed block offset width and unsigned board coordinate width.
   localparam int c_off_w   = 5;
   localparam int c_coord_w = 5;

   // Working width for origin + offset: covers -16 .. 46 with sign.
   localparam int c_sum_w   = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/tetron_cell_addr.sv
`default_nettype none
// ============================================================================
//  Module      : tetron_cell_addr
//  Description : Purely combinational cell address generator. Adds a signed
//                block offset to an unsigned piece origin and flags whether
//                the resulting cell lies on the playfield.
//  Ports       : origin_row/origin_col  unsigned pivot coordinates
//                voffset/hoffset        signed two's-complement offsets
//                row/col                low bits of the resulting coordinate
//                in_bounds              1 when 0<=row<BOARD_H, 0<=col<BOARD_W
//  Revision    : 1.0  initial release
// ============================================================================
module tetron_cell_addr
   import tetris_pkg::*;
#(
   parameter int BOARD_W = c_board_w,
   parameter int BOARD_H = c_board_h
)
(
   input  logic [c_coord_w-1:0] origin_row,
   input  logic [c_coord_w-1:0] origin_col,
   input  logic [c_off_w-1:0]   voffset,
   input  logic [c_off_w-1:0]   hoffset,
   output logic [c_coord_w-1:0] row,
   output logic [c_coord_w-1:0] col,
   output logic                 in_bounds
);

   localparam logic signed [c_sum_w-1:0] c_row_lim = c_sum_w'(BOARD_H);
   localparam logic signed [c_sum_w-1:0] c_col_lim = c_sum_w'(BOARD_W);

   logic signed [c_sum_w-1:0] w_row_s;
   logic signed [c_sum_w-1:0] w_col_s;

   always_comb begin
      // Origin is zero-extended, offset sign-extended, both into 7 bits.
      w_row_s   = $signed({2'b00, origin_row})
                + $signed({{(c_sum_w-c_off_w){voffset[c_off_w-1]}}, voffset});
      w_col_s   = $signed({2'b00, origin_col})
                + $signed({{(c_sum_w-c_off_w){hoffset[c_off_w-1]}}, hoffset});
      in_bounds = !w_row_s[c_sum_w-1] && (w_row_s < c_row_lim)
               && !w_col_s[c_sum_w-1] && (w_col_s < c_col_lim);
      row       = w_row_s[c_coord_w-1:0];
      col       = w_col_s[c_coord_w-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/tetron_collision_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tetron_collision_checker
//  Description : Decides whether a candidate tetromino placement is legal.
//                The four cells are walked one per cycle; out-of-bounds cells
//                raise hit_wall, in-bounds cells are read from the board and
//                an occupied one raises hit_block. Latency is fixed: a start
//                accepted at edge E0 yields done sampled high at E6.
//  Ports       : clk, rst                 clock, sync active-high reset
//                start                    check request (ignored while busy)
//                origin_row/origin_col    candidate pivot
//                blkN_voffset/hoffset     signed per-block offsets, N=1..4
//                rd_en/rd_row/rd_col      board read request
//                rd_data                  occupancy of previous cycle's read
//                busy, done               status / one-cycle result strobe
//                collide, hit_wall, hit_block  results, held until next start
//  Revision    : 1.0  initial release
// ============================================================================
module tetron_collision_checker
   import tetris_pkg::*;
#(
   parameter int BOARD_W = c_board_w,
   parameter int BOARD_H = c_board_h
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [c_coord_w-1:0] origin_row,
   input  logic [c_coord_w-1:0] origin_col,
   input  logic [c_off_w-1:0]   blk1_voffset,
   input  logic [c_off_w-1:0]   blk1_hoffset,
   input  logic [c_off_w-1:0]   blk2_voffset,
   input  logic [c_off_w-1:0]   blk2_hoffset,
   input  logic [c_off_w-1:0]   blk3_voffset,
   input  logic [c_off_w-1:0]   blk3_hoffset,
   input  logic [c_off_w-1:0]   blk4_voffset,
   input  logic [c_off_w-1:0]   blk4_hoffset,
   output logic                 rd_en,
   output logic [c_coord_w-1:0] rd_row,
   output logic [c_coord_w-1:0] rd_col,
   input  logic                 rd_data,
   output logic                 busy,
   output logic                 done,
   output logic                 collide,
   output logic                 hit_wall,
   output logic                 hit_block
);

   chk_state_t r_state;
   chk_state_t w_next;

   logic [1:0]           r_k;
   logic                 r_pend;
   logic [c_coord_w-1:0] r_orow;
   logic [c_coord_w-1:0] r_ocol;
   logic [c_off_w-1:0]   r_voff [4];
   logic [c_off_w-1:0]   r_hoff [4];

   logic                 w_accept;
   logic [c_coord_w-1:0] w_row;
   logic [c_coord_w-1:0] w_col;
   logic                 w_inb;

   // Address for the cell currently selected by r_k.
   tetron_cell_addr #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H)
   ) u_addr (
      .origin_row (r_orow),
      .origin_col (r_ocol),
      .voffset    (r_voff[r_k]),
      .hoffset    (r_hoff[r_k]),
      .row        (w_row),
      .col        (w_col),
      .in_bounds  (w_inb)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      rd_en    = 1'b0;
      rd_row   = '0;
      rd_col   = '0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            busy  = 1'b1;
            rd_en = w_inb;
            if (w_inb) begin
               rd_row = w_row;
               rd_col = w_col;
            end
            if (r_k == 2'd3) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy   = 1'b1;
            w_next = ST_DONE;
         end
         ST_DONE: begin
            // Not busy here, so a start on this edge chains back-to-back.
            done = 1'b1;
            if (start) begin
               w_accept = 1'b1;
               w_next   = ST_ISSUE;
            end else begin
               w_next   = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k       <= 2'd0;
         r_pend    <= 1'b0;
         r_orow    <= '0;
         r_ocol    <= '0;
         r_voff    <= '{default: '0};
         r_hoff    <= '{default: '0};
         hit_wall  <= 1'b0;
         hit_block <= 1'b0;
      end else begin
         // Marks that rd_data next cycle answers an in-bounds read.
         r_pend <= (r_state == ST_ISSUE) && w_inb;
         if (w_accept) begin
            r_k       <= 2'd0;
            r_orow    <= origin_row;
            r_ocol    <= origin_col;
            r_voff[0] <= blk1_voffset;
            r_voff[1] <= blk2_voffset;
            r_voff[2] <= blk3_voffset;
            r_voff[3] <= blk4_voffset;
            r_hoff[0] <= blk1_hoffset;
            r_hoff[1] <= blk2_hoffset;
            r_hoff[2] <= blk3_hoffset;
            r_hoff[3] <= blk4_hoffset;
            hit_wall  <= 1'b0;
            hit_block <= 1'b0;
         end else begin
            if (r_state == ST_ISSUE) begin
               r_k <= r_k + 2'd1;
               if (!w_inb) hit_wall <= 1'b1;
            end
            if (r_pend && rd_data) hit_block <= 1'b1;
         end
      end
   end

   assign collide = hit_wall | hit_block;

endmodule
`default_nettype wire

// File: tb/tb_tetron_collision_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tetron_collision_checker
//  Description : Self-checking bench: directed placements plus randomized
//                boards/pieces compared against a per-cell reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tetron_collision_checker;
   import tetris_pkg::*;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] origin_row;
   logic [4:0] origin_col;
   logic [4:0] in_v [4];
   logic [4:0] in_h [4];
   logic       rd_en;
   logic [4:0] rd_row;
   logic [4:0] rd_col;
   logic       rd_data = 1'b0;
   logic       busy;
   logic       done;
   logic       collide;
   logic       hit_wall;
   logic       hit_block;

   int n_vec = 0;
   int n_err = 0;

   bit         board [BOARD_H][BOARD_W];
   logic [9:0] rd_log [$];
   logic [9:0] e_rd [$];
   bit         e_wall;
   bit         e_blk;

   tetron_collision_checker #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .origin_row   (origin_row),
      .origin_col   (origin_col),
      .blk1_voffset (in_v[0]),
      .blk1_hoffset (in_h[0]),
      .blk2_voffset (in_v[1]),
      .blk2_hoffset (in_h[1]),
      .blk3_voffset (in_v[2]),
      .blk3_hoffset (in_h[2]),
      .blk4_voffset (in_v[3]),
      .blk4_hoffset (in_h[3]),
      .rd_en        (rd_en),
      .rd_row       (rd_row),
      .rd_col       (rd_col),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .collide      (collide),
      .hit_wall     (hit_wall),
      .hit_block    (hit_block)
   );

   always #5 clk = ~clk;

   // Board memory with one-cycle read latency; garbage when not read.
   always @(posedge clk) begin
      if (rd_en && int'(rd_row) < BOARD_H && int'(rd_col) < BOARD_W)
         rd_data <= board[rd_row][rd_col];
      else
         rd_data <= 1'($urandom);
      if (rd_en) rd_log.push_back({rd_row, rd_col});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_board();
      for (int r = 0; r < BOARD_H; r++)
         for (int c = 0; c < BOARD_W; c++)
            board[r][c] = 1'b0;
   endtask

   task automatic set_piece(input int orow, input int ocol,
                            input int v0, input int h0, input int v1, input int h1,
                            input int v2, input int h2, input int v3, input int h3);
      origin_row = 5'(orow);
      origin_col = 5'(ocol);
      in_v[0] = 5'(v0); in_h[0] = 5'(h0);
      in_v[1] = 5'(v1); in_h[1] = 5'(h1);
      in_v[2] = 5'(v2); in_h[2] = 5'(h2);
      in_v[3] = 5'(v3); in_h[3] = 5'(h3);
   endtask

   // Reference: plain integer geometry over the four cells.
   task automatic model_eval();
      e_wall = 1'b0;
      e_blk  = 1'b0;
      e_rd.delete();
      for (int i = 0; i < 4; i++) begin
         int r;
         int c;
         r = int'(origin_row) + int'($signed(in_v[i]));
         c = int'(origin_col) + int'($signed(in_h[i]));
         if (r < 0 || r >= BOARD_H || c < 0 || c >= BOARD_W) begin
            e_wall = 1'b1;
         end else begin
            e_rd.push_back({5'(r), 5'(c)});
            if (board[r][c]) e_blk = 1'b1;
         end
      end
   endtask

   task automatic run_check(input string tag, input bit disturb);
      int n;
      model_eval();
      rd_log.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (disturb) begin
         origin_row = 5'($urandom);
         origin_col = 5'($urandom);
         for (int i = 0; i < 4; i++) begin
            in_v[i] = 5'($urandom);
            in_h[i] = 5'($urandom);
         end
      end
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (disturb && n == 2) start = 1'b1;
         if (n == 3) start = 1'b0;
      end
      check({tag, " done_edge"}, n + 1, 6);
      check({tag, " busy_at_done"}, busy, 1'b0);
      check({tag, " hit_wall"}, hit_wall, e_wall);
      check({tag, " hit_block"}, hit_block, e_blk);
      check({tag, " collide"}, collide, e_wall | e_blk);
      check({tag, " n_reads"}, rd_log.size(), e_rd.size());
      if (rd_log.size() == e_rd.size())
         for (int i = 0; i < e_rd.size(); i++)
            check({tag, " rd_addr"}, rd_log[i], e_rd[i]);
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, done, 1'b0);
      check({tag, " collide_held"}, collide, e_wall | e_blk);
   endtask

   initial begin
      int dn;
      int dpos [$];
      rst   = 1'b1;
      start = 1'b0;
      set_piece(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clear_board();
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst collide", collide, 1'b0);
      check("rst hit_wall", hit_wall, 1'b0);
      check("rst hit_block", hit_block, 1'b0);
      check("rst rd_en", rd_en, 1'b0);
      check("rst rd_addr", {rd_row, rd_col}, 10'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Empty board, legal placement.
      set_piece(5, 4, 0, 0, 0, 1, 0, -1, 1, -1);
      run_check("empty", 1'b0);
      // Same piece, (6,3) occupied.
      board[6][3] = 1'b1;
      set_piece(5, 4, 0, 0, 0, 1, 0, -1, 1, -1);
      run_check("blocked", 1'b0);
      clear_board();
      // Left wall: one cell at column -1.
      set_piece(5, 0, 0, 0, 0, 1, 0, -1, 1, 0);
      run_check("left_wall", 1'b0);
      // Floor: row 20.
      set_piece(19, 4, 0, 0, 0, 1, 0, -1, 1, 0);
      run_check("floor", 1'b0);
      // Right wall and in-bounds block combined, inputs disturbed while busy.
      board[3][8] = 1'b1;
      set_piece(3, 9, 0, 0, 0, 1, 0, -1, -1, 0);
      run_check("right_wall_blk", 1'b1);

      // Randomized boards and pieces.
      for (int t = 0; t < 40; t++) begin
         for (int r = 0; r < BOARD_H; r++)
            for (int c = 0; c < BOARD_W; c++)
               board[r][c] = ($urandom_range(0, 99) < 20);
         if (t % 4 == 3)
            set_piece($urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom);
         else
            set_piece($urandom_range(0, 21), $urandom_range(0, 11),
                      $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2,
                      $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2,
                      $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2,
                      $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2);
         run_check("rand", t[0]);
      end

      // start held high: checks chain at E0, E6, E12.
      clear_board();
      set_piece(10, 5, 0, 0, 1, 0, 2, 0, 3, 0);
      start = 1'b1;
      dpos.delete();
      for (int e = 0; e < 18; e++) begin
         @(posedge clk); #1;
         if (done) dpos.push_back(e);
         if (e == 6) check("chain busy_after_E6", busy, 1'b1);
      end
      start = 1'b0;
      check("chain n_done", dpos.size(), 3);
      if (dpos.size() == 3) begin
         check("chain done0", dpos[0], 5);
         check("chain done1", dpos[1], 11);
         check("chain done2", dpos[2], 17);
      end
      check("chain collide", collide, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-check aborts without a done.
      set_piece(19, 0, 0, 0, 1, 0, 0, -1, 0, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort collide", collide, 1'b0);
      check("abort hit_wall", hit_wall, 1'b0);
      check("abort hit_block", hit_block, 1'b0);
      check("abort rd_en", rd_en, 1'b0);
      dn = 0;
      for (int e = 0; e < 8; e++) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      check("abort no_done", dn, 0);
      board[7][2] = 1'b1;
      set_piece(6, 2, 0, 0, 1, 0, 0, 1, -1, 0);
      run_check("after_abort", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
